// File: rtl/tr_acc.sv
// tr_acc: transaction accumulator.
// Sums the payloads of each inner transaction on a two-level din queue. It
// emits one result word per inner transaction on a one-level dout queue. The
// outer end-of-transaction flag of the terminating word is carried along.
// Optional build macro: TR_ACC_SAT_EN. When it is defined, the additions
// saturate at all-ones. When it is undefined, the sum wraps modulo 2^W_ACC.
module tr_acc #(
    parameter int unsigned W_DATA = 16,
    parameter int unsigned W_ACC  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [W_DATA+1:0] din_data,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [W_ACC:0]    dout_data
);

    logic [W_ACC-1:0] acc;
    logic [W_ACC:0]   out_reg;
    logic             out_valid;

    logic [W_ACC-1:0] payload_ext;
    logic [W_ACC-1:0] sum;
    logic             din_xfer;
    logic             dout_xfer;
    logic             eot_inner;
    logic             eot_outer;

    assign eot_outer = din_data[W_DATA+1];
    assign eot_inner = din_data[W_DATA];

    // Input is accepted whenever the output slot is free or is being drained this cycle
    assign din_ready  = !out_valid || dout_ready;
    assign din_xfer   = din_valid && din_ready;
    assign dout_xfer  = out_valid && dout_ready;

    assign dout_valid = out_valid;
    assign dout_data  = out_reg;

    // Zero-extend the payload to accumulator width
    always_comb begin
        payload_ext = '0;
        payload_ext[W_DATA-1:0] = din_data[W_DATA-1:0];
    end

`ifdef TR_ACC_SAT_EN
    logic [W_ACC:0] sum_wide;

    // Saturating add: a carry out of the top bit clamps the result to all-ones
    always_comb begin
        sum_wide = {1'b0, acc} + {1'b0, payload_ext};
        sum      = sum_wide[W_ACC] ? '1 : sum_wide[W_ACC-1:0];
    end
`else
    // Wrapping add: the carry out is discarded
    always_comb begin
        sum = acc + payload_ext;
    end
`endif

    // Accumulator: adds non-terminating words and clears on the terminating word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (din_xfer) begin
            if (eot_inner) begin
                acc <= '0;
            end else begin
                acc <= sum;
            end
        end
    end

    // Result register: a new result may replace one being drained in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_reg   <= '0;
            out_valid <= 1'b0;
        end else if (din_xfer && eot_inner) begin
            out_reg   <= {eot_outer, sum};
            out_valid <= 1'b1;
        end else if (dout_xfer) begin
            out_valid <= 1'b0;
        end
    end

endmodule
